// File: rtl/iir_cascade_param_if.sv
// rtl/iir_cascade_param_if.sv - sample stream into and filtered stream out of the IIR cascade
interface iir_cascade_param_if #(
    parameter int DATA_W = 64,
    parameter int WARM_W = 20
);
    logic                     data_valid;
    logic signed [DATA_W-1:0] data;
    logic signed [DATA_W-1:0] data_out;
    logic                     data_out_valid;
    logic                     ready;
    logic [WARM_W-1:0]        warm_count;

    modport master (
        output data_valid, data,
        input  data_out, data_out_valid, ready, warm_count
    );

    modport slave (
        input  data_valid, data,
        output data_out, data_out_valid, ready, warm_count
    );
endinterface

// File: rtl/iir_cascade_param.sv
// rtl/iir_cascade_param.sv - run-time configurable cascade of first-order IIR low-pass sections
module iir_cascade_param #(
    parameter int DATA_W     = 64,
    parameter int FRAC_W     = 16,
    parameter int MAX_STAGES = 8,
    parameter int WARM_W     = 20
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [4:0]           n_stages,
    input  logic [3:0]           k_shift,
    input  logic                 preload,
    iir_cascade_param_if.slave   st
);
    localparam int ACC_W = DATA_W + FRAC_W;
    localparam int TW    = WARM_W + 21;

    typedef enum logic [1:0] {IDLE, LATCH, WARM, RUN} state_t;
    state_t state, state_next;

    logic                     enable_q;
    logic [4:0]               n_eff_q;
    logic [3:0]               k_q;
    logic                     preload_q;
    logic                     pre_done;
    logic [WARM_W-1:0]        target_q;

    logic signed [ACC_W-1:0]  y         [MAX_STAGES];
    logic signed [ACC_W-1:0]  y_next    [MAX_STAGES];
    logic signed [ACC_W:0]    diff      [MAX_STAGES];
    logic signed [ACC_W:0]    step      [MAX_STAGES];
    logic signed [DATA_W-1:0] stage_out [MAX_STAGES+1];
    logic [MAX_STAGES-1:0]    vq;
    logic [MAX_STAGES:0]      v_all;

    logic                     filtering, in_fire, preload_fire;
    logic signed [ACC_W-1:0]  xe_in;
    logic signed [DATA_W-1:0] sel_data;
    logic                     sel_valid;
    logic [4:0]               n_clamp;
    logic [TW-1:0]            target_wide;
    logic [WARM_W-1:0]        target_sat;
    logic [WARM_W:0]          warm_inc;

    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic [WARM_W-1:0]        warm;

    assign st.data_out       = out_data;
    assign st.data_out_valid = out_valid;
    assign st.warm_count     = warm;
    assign st.ready          = (state == RUN);

    always_comb begin
        filtering    = enable && (state == WARM || state == RUN);
        in_fire      = filtering && st.data_valid;
        preload_fire = in_fire && preload_q && !pre_done;
        v_all        = {vq, in_fire};
        xe_in        = {st.data, {FRAC_W{1'b0}}};
        stage_out[0] = st.data;
        for (int i = 0; i < MAX_STAGES; i++) begin
            stage_out[i+1] = y[i][ACC_W-1:FRAC_W];
        end
        // diff carries one extra bit so the subtraction of two ACC_W values cannot wrap
        for (int i = 0; i < MAX_STAGES; i++) begin
            diff[i]   = $signed({stage_out[i][DATA_W-1], stage_out[i], {FRAC_W{1'b0}}})
                      - $signed({y[i][ACC_W-1], y[i]});
            step[i]   = diff[i] >>> k_q;
            y_next[i] = y[i] + step[i][ACC_W-1:0];
        end
        sel_data  = stage_out[0];
        sel_valid = v_all[0];
        for (int i = 1; i <= MAX_STAGES; i++) begin
            if (n_eff_q == 5'(i)) begin
                sel_data  = stage_out[i];
                sel_valid = v_all[i];
            end
        end
        n_clamp     = (n_stages > 5'(MAX_STAGES)) ? 5'(MAX_STAGES) : n_stages;
        target_wide = TW'(n_clamp) << k_shift;
        target_sat  = (target_wide > TW'({WARM_W{1'b1}})) ? '1 : target_wide[WARM_W-1:0];
        warm_inc    = {1'b0, warm} + 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (enable && !enable_q) state_next = LATCH;
            LATCH: state_next = WARM;
            WARM:  if (out_valid && (preload_q || target_q == '0 || warm_inc >= {1'b0, target_q}))
                       state_next = RUN;
            RUN:   state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (!enable) state_next = IDLE;
    end

    // enable_q resets high so an enable held across reset release needs a fresh rising edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            enable_q <= 1'b1;
        end else begin
            state    <= state_next;
            enable_q <= enable;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            n_eff_q   <= '0;
            k_q       <= '0;
            preload_q <= 1'b0;
            target_q  <= '0;
        end else if (state == LATCH) begin
            n_eff_q   <= n_clamp;
            k_q       <= k_shift;
            preload_q <= preload;
            target_q  <= target_sat;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_STAGES; i++) y[i] <= '0;
            vq        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            warm      <= '0;
            pre_done  <= 1'b0;
        end else if (!filtering) begin
            for (int i = 0; i < MAX_STAGES; i++) y[i] <= '0;
            vq        <= '0;
            out_valid <= 1'b0;
            warm      <= '0;
            pre_done  <= 1'b0;
        end else begin
            vq <= v_all[MAX_STAGES-1:0];
            for (int i = 0; i < MAX_STAGES; i++) begin
                if (preload_fire)  y[i] <= xe_in;
                else if (v_all[i]) y[i] <= y_next[i];
            end
            if (preload_fire) pre_done <= 1'b1;
            out_valid <= sel_valid;
            if (sel_valid) out_data <= sel_data;
            if (out_valid && warm != '1) warm <= warm + 1'b1;
        end
    end
endmodule
